uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Frame controller that sits directly behind the UART receiver. It consumes the byte stream (`rx_byte`/`rx_valid`), parses fixed-format register-write frames, and issues single-cycle register writes to the board's control register file (7-segment digits, LEDs, PMOD config). It also enforces an inter-byte timeout and counts malformed frames, so a dropped or garbled byte never leaves the parser stuck mid-frame.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 8680: max idle clocks between bytes inside a frame (4 byte-times at 115200 baud, 25 MHz).
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `i_clk` input 1: system clock.
- `i_reset` input 1: synchronous, active-high reset.
- `i_rx_byte` input 8: received byte from UART receiver.
- `i_rx_valid` input 1: one-cycle strobe; `i_rx_byte` valid this cycle.
- `o_wr_addr` output 4: register address.
- `o_wr_data` output 8: register write data.
- `o_wr_en` output 1: one-cycle write strobe.
- `o_frame_err` output 1: one-cycle strobe on any frame rejection.
- `o_err_count` output 8: saturating count of frame errors.
- `o_busy` output 1: high while the parser is mid-frame (state != IDLE).

## Operation
- Frame: SYNC, ADDR, DATA[, CSUM]. ADDR[7:4] must be 0; ADDR[3:0] becomes `o_wr_addr`.
- States: IDLE, ADDR, DATA, CSUM (CSUM exists only with the checksum macro).
- IDLE: a byte equal to SYNC_BYTE goes to ADDR. Any other byte is dropped silently, with no error.
- ADDR: if byte[7:4] != 0, raise the error and go to IDLE. Otherwise latch the address and go to DATA.
- DATA: latch the data byte.
  - Without checksum: issue the write and go to IDLE.
  - With checksum: go to CSUM.
- CSUM: the expected value is (SYNC_BYTE + ADDR + DATA) mod 256, 8-bit wrap.
  - Match: issue the write, go to IDLE.
  - Mismatch: raise the error, go to IDLE, no write.
- A SYNC_BYTE value arriving in the ADDR, DATA or CSUM state is treated as ordinary data. There is no resync mid-frame.
- Timeout counter:
  - Cleared on every `i_rx_valid` and while in IDLE; increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES in a non-IDLE state: raise the error, go to IDLE.
  - `i_rx_valid` and timeout in the same cycle: the byte wins, the counter clears, no error.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Error count: `o_err_count` increments on each `o_frame_err`, saturates at 255, and clears only on reset.

## Timing
- All outputs are registered.
- Reset values: `o_wr_addr`=0, `o_wr_data`=0, `o_wr_en`=0, `o_frame_err`=0, `o_err_count`=0, `o_busy`=0, state=IDLE, timeout counter=0.
- Write strobe: `o_wr_en` is high for exactly the one cycle after the `i_rx_valid` cycle of the final frame byte. `o_wr_addr`/`o_wr_data` are valid in that cycle and hold until the next write.
- Error strobe: `o_frame_err` is high for exactly the one cycle after the rejecting byte or the timeout cycle. `o_err_count` updates in the same cycle as `o_frame_err`.
- `o_busy` rises the cycle after SYNC is accepted. It falls in the same cycle as the `o_wr_en` or `o_frame_err` strobe.
- Back-to-back frames: a SYNC byte on the cycle immediately after a write strobe must be accepted.
- `i_reset` mid-frame: abandon the frame with no write and no error; `o_err_count` clears.
- No backpressure: every `i_rx_valid` byte is consumed in its cycle.

## Configuration
- `UART_CMD_CHECKSUM_EN` defined:
  - 4-byte frames; CSUM state present; mismatch is an error.
- Not defined:
  - 3-byte frames; CSUM state and adder logic are absent.
  - The write issues right after DATA.

## Test plan
- Valid frame: A5, 03, 5C (with checksum: A5, 03, 5C, 04) -> one `o_wr_en` pulse with addr=3, data=8'h5C; `o_frame_err` never asserts.
- Garbage then frame: 00, FF, 12 before the frame in test 1 -> garbage ignored, same single write, `o_err_count`=0.
- Bad address: A5, 13 -> `o_frame_err` pulse, no write, `o_err_count`=1, `o_busy` low after.
- Checksum (macro on): A5, 03, 5C, 05 -> error and no write. Also A5, 0F, FF, B3 (wrap: A5+0F+FF = 0x1B3) -> write addr=F, data=FF.
- Timeout: A5 then silence for TIMEOUT_CYCLES -> error pulse exactly on timeout. A byte arriving on cycle TIMEOUT_CYCLES-1 -> no error.
- Saturation and reset: 260 bad-address frames -> `o_err_count`=255. Then `i_reset` mid-frame -> all outputs 0; the next valid frame writes normally.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Register-write frame parser behind the UART receiver: SYNC, ADDR, DATA[, CSUM] -> one-cycle write strobe.
// Build option: define UART_CMD_CHECKSUM_EN to require a trailing (SYNC+ADDR+DATA) mod 256 checksum byte.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 8680,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    output logic [3:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_wr_en,
    output logic       o_frame_err,
    output logic [7:0] o_err_count,
    output logic       o_busy
);
    localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
`ifdef UART_CMD_CHECKSUM_EN
        , S_CSUM
`endif
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic [3:0]       frame_addr_q;
    logic [3:0]       wr_addr_q;
    logic [7:0]       wr_data_q;
    logic             wr_en_q;
    logic             frame_err_q;
    logic [7:0]       err_count_q;
    logic             busy_q;

    logic             wr_en_d;
    logic             frame_err_d;
    logic [7:0]       wr_data_d;

`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0] frame_data_q;
    logic [7:0] csum;
    assign csum = SYNC_BYTE + {4'h0, frame_addr_q} + frame_data_q;
`endif

    // Decode this cycle's write/reject decision; a received byte always pre-empts the timeout.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_en_d     = 1'b0;
        frame_err_d = 1'b0;
        wr_data_d   = i_rx_byte;
        if (i_rx_valid) begin
            case (state_q)
                S_ADDR: frame_err_d = (i_rx_byte[7:4] != 4'h0);
`ifdef UART_CMD_CHECKSUM_EN
                S_CSUM: begin
                    wr_en_d     = (i_rx_byte == csum);
                    frame_err_d = (i_rx_byte != csum);
                    wr_data_d   = frame_data_q;
                end
`else
                S_DATA: wr_en_d = 1'b1;
`endif
                default: ;
            endcase
        end else if (state_q != S_IDLE && tmo_cnt_q == CNT_MAX) begin
            frame_err_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            tmo_cnt_q    <= '0;
            frame_addr_q <= 4'h0;
`ifdef UART_CMD_CHECKSUM_EN
            frame_data_q <= 8'h00;
`endif
            wr_addr_q    <= 4'h0;
            wr_data_q    <= 8'h00;
            wr_en_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
            if (frame_err_d && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
            if (wr_en_d) begin
                wr_addr_q <= frame_addr_q;
                wr_data_q <= wr_data_d;
            end
            if (i_rx_valid || state_q == S_IDLE) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end

            if (wr_en_d || frame_err_d) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else if (i_rx_valid) begin
                case (state_q)
                    S_IDLE: begin
                        if (i_rx_byte == SYNC_BYTE) begin
                            state_q <= S_ADDR;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        frame_addr_q <= i_rx_byte[3:0];
                        state_q      <= S_DATA;
                    end
`ifdef UART_CMD_CHECKSUM_EN
                    S_DATA: begin
                        frame_data_q <= i_rx_byte;
                        state_q      <= S_CSUM;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_wr_en     = wr_en_q;
    assign o_frame_err = frame_err_q;
    assign o_err_count = err_count_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized bench for uart_cmd_ctrl: a frame-level model predicts the cycle and content of every
// write/error strobe; a negedge monitor compares them. Works with or without UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_ctrl;
    localparam int         TO   = 40;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_CMD_CHECKSUM_EN
    localparam int FLEN = 4;
`else
    localparam int FLEN = 3;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] rx_byte  = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_wr_en;
    logic       o_frame_err;
    logic [7:0] o_err_count;
    logic       o_busy;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(SYNC)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx_byte   (rx_byte),
        .i_rx_valid  (rx_valid),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_wr_en     (o_wr_en),
        .o_frame_err (o_frame_err),
        .o_err_count (o_err_count),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         is_err;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] cnt;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    bit         mon_en   = 1'b0;
    bit         m_in_frame;
    int         m_idx;
    int         m_last_s;
    int         m_err_total;
    logic [7:0] m_fb [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void push_ev(input int c, input bit e, input logic [3:0] a, input logic [7:0] d);
        ev_t ev;
        if (e && m_err_total < 255) m_err_total++;
        ev.cyc    = c;
        ev.is_err = e;
        ev.addr   = a;
        ev.data   = d;
        ev.cnt    = 8'(m_err_total);
        exp_q.push_back(ev);
    endfunction

    // A frame in progress is dropped if more than TO idle cycles separate two of its bytes.
    function automatic void model_timeout(input int next_s);
        if (m_in_frame && (next_s - m_last_s - 1) > TO) begin
            push_ev(m_last_s + TO + 1, 1'b1, 4'h0, 8'h00);
            m_in_frame = 1'b0;
        end
    endfunction

    function automatic void model_byte(input int s, input logic [7:0] b);
        if (!m_in_frame) begin
            if (b == SYNC) begin
                m_in_frame = 1'b1;
                m_idx      = 1;
            end
        end else begin
            m_fb[m_idx] = b;
            m_idx++;
            if (m_idx == 2 && b[7:4] != 4'h0) begin
                push_ev(s, 1'b1, 4'h0, 8'h00);
                m_in_frame = 1'b0;
            end else if (m_idx == FLEN) begin
`ifdef UART_CMD_CHECKSUM_EN
                if (b == 8'(SYNC + m_fb[1] + m_fb[2])) push_ev(s, 1'b0, m_fb[1][3:0], m_fb[2]);
                else                                   push_ev(s, 1'b1, 4'h0, 8'h00);
`else
                push_ev(s, 1'b0, m_fb[1][3:0], m_fb[2]);
`endif
                m_in_frame = 1'b0;
            end
        end
        m_last_s = s;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input int gap, input logic [7:0] b);
        int s;
        s = cyc + gap + 1;
        model_timeout(s);
        model_byte(s, b);
        repeat (gap) tick();
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        model_timeout(cyc + n + 1);
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input int gap, input bit bad_cs);
        send(gap, SYNC);
        send(gap, a);
        send(gap, d);
`ifdef UART_CMD_CHECKSUM_EN
        send(gap, 8'(SYNC + a + d) ^ {7'd0, bad_cs});
`else
        if (bad_cs) send(gap, 8'h00);
`endif
    endtask

    always @(negedge clk) begin
        bit  ew;
        bit  ee;
        ev_t ev;
        if (mon_en) begin
            ew = 1'b0;
            ee = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                ev = exp_q.pop_front();
                ew = !ev.is_err;
                ee = ev.is_err;
            end
            if (ew || ee || o_wr_en || o_frame_err) begin
                check("wr_en", 32'(o_wr_en), 32'(ew));
                check("frame_err", 32'(o_frame_err), 32'(ee));
                if (ew) begin
                    check("wr_addr", 32'(o_wr_addr), 32'(ev.addr));
                    check("wr_data", 32'(o_wr_data), 32'(ev.data));
                end
                if (ew || ee) check("err_count", 32'(o_err_count), 32'(ev.cnt));
            end
        end
    end

    initial begin
        m_in_frame  = 1'b0;
        m_idx       = 0;
        m_last_s    = 0;
        m_err_total = 0;

        tick();
        tick();
        check("rst_wr_addr", 32'(o_wr_addr), 32'h0);
        check("rst_wr_data", 32'(o_wr_data), 32'h0);
        check("rst_wr_en", 32'(o_wr_en), 32'h0);
        check("rst_frame_err", 32'(o_frame_err), 32'h0);
        check("rst_err_count", 32'(o_err_count), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Garbage ahead of a valid frame is silently ignored.
        send(0, 8'h00);
        send(0, 8'hFF);
        send(0, 8'h12);
        send_frame(8'h03, 8'h5C, 0, 1'b0);
        idle(3);
        check("hold_addr", 32'(o_wr_addr), 32'h3);
        check("hold_data", 32'(o_wr_data), 32'h5C);
        check("garbage_errcnt", 32'(o_err_count), 32'h0);

        send(0, SYNC);
        check("busy_rise", 32'(o_busy), 32'h1);
        send(0, 8'h13);
        check("busy_after_badaddr", 32'(o_busy), 32'h0);
        check("errcnt_badaddr", 32'(o_err_count), 32'h1);
        idle(2);

        send(0, SYNC);
        idle(TO + 3);
        check("busy_after_timeout", 32'(o_busy), 32'h0);
        check("errcnt_timeout", 32'(o_err_count), 32'h2);

        // Gaps of TO-1 and TO idle cycles are still inside the window; TO+1 is not.
        send(0, SYNC);
        send(TO - 1, 8'h07);
        send(TO, 8'h99);
`ifdef UART_CMD_CHECKSUM_EN
        send(TO, 8'(SYNC + 8'h07 + 8'h99));
`endif
        send(0, SYNC);
        send(TO + 1, 8'h01);
        idle(2);

        send_frame(8'h01, 8'h11, 0, 1'b0);
        send_frame(8'h02, 8'h22, 0, 1'b0);
        idle(2);
        check("b2b_addr", 32'(o_wr_addr), 32'h2);
        check("b2b_data", 32'(o_wr_data), 32'h22);

`ifdef UART_CMD_CHECKSUM_EN
        send(0, SYNC); send(0, 8'h03); send(0, 8'h5C); send(0, 8'h05);
        send(0, SYNC); send(0, 8'h0F); send(0, 8'hFF); send(0, 8'hB3);
        idle(2);
        check("csum_wrap_addr", 32'(o_wr_addr), 32'hF);
        check("csum_wrap_data", 32'(o_wr_data), 32'hFF);
`endif

        for (int i = 0; i < 150; i++) begin
            int         g;
            logic [7:0] a;
            logic [7:0] d;
            repeat ($urandom_range(0, 2)) send($urandom_range(0, 3), 8'($urandom));
            a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
            d = 8'($urandom);
            g = ($urandom_range(0, 7) == 0) ? (TO - 1 + int'($urandom_range(0, 2))) : int'($urandom_range(0, 2));
            send_frame(a, d, g, $urandom_range(0, 5) == 0);
        end
        idle(TO + 3);

        for (int i = 0; i < 260; i++) begin
            send(0, SYNC);
            send(0, {4'($urandom_range(1, 15)), 4'($urandom)});
        end
        idle(2);
        check("errcnt_saturated", 32'(o_err_count), 32'd255);

        // Reset mid-frame abandons the frame silently and clears the error count.
        send(0, SYNC);
        send(0, 8'h04);
        rst        = 1'b1;
        m_in_frame = 1'b0;
        m_err_total = 0;
        tick();
        check("midrst_wr_addr", 32'(o_wr_addr), 32'h0);
        check("midrst_wr_data", 32'(o_wr_data), 32'h0);
        check("midrst_wr_en", 32'(o_wr_en), 32'h0);
        check("midrst_frame_err", 32'(o_frame_err), 32'h0);
        check("midrst_err_count", 32'(o_err_count), 32'h0);
        check("midrst_busy", 32'(o_busy), 32'h0);
        tick();
        rst = 1'b0;
        send_frame(8'h0A, 8'h3C, 0, 1'b0);
        idle(3);
        check("postrst_addr", 32'(o_wr_addr), 32'hA);
        check("postrst_data", 32'(o_wr_data), 32'h3C);
        check("postrst_errcnt", 32'(o_err_count), 32'h0);

        idle(TO + 5);
        check("pending_events", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
